// File: rtl/top_tx_if.sv
// top_tx_if -- handshake and serial-stream bundle for the top_tx serializer.
// master: frame source (drives load/data_in); slave: the serializer itself.
interface top_tx_if #(
  parameter int WIDTH = 4
) ();
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             data_out;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output data_in,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  data_in,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/top_tx.sv
// top_tx -- parallel-to-serial frame transmitter, MSB first.
// A load seen in IDLE captures data_in and shifts it out over WIDTH cycles,
// followed by a one-cycle done pulse in the first IDLE cycle.
// Optional feature macro: PARITY_EN appends one even-parity bit per frame.
// The WIDTH-bit shift register is split as {data_out_r, shreg_r}: data_out_r
// is its MSB stage and drives the pin directly, so the output is registered
// and the first bit appears the cycle after the accepting edge.
module top_tx #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  top_tx_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t             state_r;
  logic [WIDTH-2:0]   shreg_r;     // remaining bits below the output stage
  logic [CNT_W-1:0]   cnt_r;       // bits already completed in this frame
  logic               data_out_r;  // MSB stage of the shift register
  logic               done_r;

`ifdef PARITY_EN
  logic               parity_r;    // even parity of the captured word

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Frame sequencer: state, shift register, bit counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      data_out_r <= 1'b0;
      done_r     <= 1'b0;
`ifdef PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.load) begin
            data_out_r <= bus.data_in[WIDTH-1];
            shreg_r    <= bus.data_in[WIDTH-2:0];
            cnt_r      <= '0;
            state_r    <= SHIFT;
`ifdef PARITY_EN
            parity_r   <= even_parity(bus.data_in);
`endif
          end else begin
            data_out_r <= 1'b0;
          end
        end

        SHIFT: begin
          shreg_r <= shreg_r << 1;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
`ifdef PARITY_EN
            data_out_r <= parity_r;
            state_r    <= PARITY;
            done_r     <= 1'b0;
`else
            data_out_r <= 1'b0;
            state_r    <= IDLE;
            done_r     <= 1'b1;
`endif
          end else begin
            data_out_r <= shreg_r[WIDTH-2];
            done_r     <= 1'b0;
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          data_out_r <= 1'b0;
          state_r    <= IDLE;
          done_r     <= 1'b1;
        end
`endif

        default: begin
          data_out_r <= 1'b0;
          state_r    <= IDLE;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = done_r;

endmodule
